// File: rtl/AXI_package.sv
// Register-interface command and status codes shared with AXI_top.
package AXI_package;
  localparam logic [31:0] CMD_NOP                = 32'd0;
  localparam logic [31:0] CMD_WRITE              = 32'd1;
  localparam logic [31:0] CMD_READ               = 32'd2;
  localparam logic [31:0] CMD_START              = 32'd3;
  localparam logic [31:0] CMD_RESET              = 32'd4;
  localparam logic [31:0] CMD_READ_ELAPSED_CLOCK = 32'd5;

  localparam logic [31:0] STATUS_IDLE     = 32'd0;
  localparam logic [31:0] STATUS_RUNNING  = 32'd1;
  localparam logic [31:0] STATUS_ACCEPTED = 32'd2;
  localparam logic [31:0] STATUS_REJECTED = 32'd3;
  localparam logic [31:0] STATUS_ERROR    = 32'd4;
endpackage

// File: rtl/cicero_seq_package.sv
// Shared types for the CICERO job sequencer: FSM states, header layout and result record.
package cicero_seq_package;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_LOAD, S_DRAIN, S_SET_PTR, S_START,
    S_WAIT_RUN, S_WAIT_DONE, S_READ_CC, S_CAPTURE, S_RESULT
  } seq_state_t;

  localparam int CW_LSB = 0;
  localparam int CW_MSB = 15;
  localparam int SB_LSB = 16;
  localparam int SB_MSB = 31;

  typedef struct packed {
    logic        accept;
    logic        error;
    logic [31:0] cycles;
  } result_t;
endpackage

// File: rtl/cicero_reg_write_issuer.sv
// Three-phase register write: accept word and latch address/data, pulse CMD_WRITE, then a settle cycle.
module cicero_reg_write_issuer #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 word_valid,
  input  logic [REG_WIDTH-1:0] word_addr,
  input  logic [REG_WIDTH-1:0] word,
  output logic                 word_ready,
  output logic                 write_pulse,
  output logic                 done,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] data_in_register
);
  typedef enum logic [1:0] {PH_A, PH_B, PH_C} phase_t;

  phase_t phase;

  assign word_ready = enable && (phase == PH_A);
  assign done       = (phase == PH_C);

  // Address and data are latched on acceptance so they are stable for the whole write pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase            <= PH_A;
      write_pulse      <= 1'b0;
      address_register <= '0;
      data_in_register <= '0;
    end else begin
      case (phase)
        PH_A: begin
          if (word_ready && word_valid) begin
            address_register <= word_addr;
            data_in_register <= word;
            write_pulse      <= 1'b1;
            phase            <= PH_B;
          end
        end
        PH_B: begin
          write_pulse <= 1'b0;
          phase       <= PH_C;
        end
        default: phase <= PH_A;
      endcase
    end
  end
endmodule

// File: rtl/cicero_job_sequencer.sv
// Streams one job into AXI_top (code, string, pointers), starts it, waits for the verdict and returns a result record.
module cicero_job_sequencer
  import AXI_package::*;
  import cicero_seq_package::*;
#(
  parameter int REG_WIDTH     = 32,
  parameter int MEM_BYTES     = 4096,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_accept,
  output logic                 res_error,
  output logic [REG_WIDTH-1:0] res_cycles,
  output logic                 busy,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] data_in_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [REG_WIDTH-1:0] data_o_register
);
  localparam int TIMER_W = $clog2(START_TIMEOUT + 1);

  seq_state_t           state;
  result_t              res;
  logic [15:0]          cw, sb;
  logic [17:0]          words_left;
  logic [REG_WIDTH-1:0] byte_addr, cmd_q, ptr_base;
  logic [TIMER_W-1:0]   timer;
  logic                 issuer_ready, issuer_done, write_pulse, accept;
  logic [15:0]          hdr_cw, hdr_sb;
  logic [17:0]          hdr_sw, hdr_words;
  logic                 hdr_bad;

  // Capacity is checked in words so the 18-bit sum cannot wrap.
  assign hdr_cw    = in_data[CW_MSB:CW_LSB];
  assign hdr_sb    = in_data[SB_MSB:SB_LSB];
  assign hdr_sw    = (18'(hdr_sb) + 18'd3) >> 2;
  assign hdr_words = 18'(hdr_cw) + hdr_sw;
  assign hdr_bad   = (hdr_sb == 16'd0) || (hdr_words > 18'(MEM_BYTES / 4));
  assign ptr_base  = REG_WIDTH'({cw, 2'b00});

  assign in_ready = (state == S_HDR) || (state == S_DRAIN) ||
                    ((state == S_LOAD) && issuer_ready);
  assign accept       = in_valid && in_ready;
  assign busy         = (state != S_IDLE);
  assign cmd_register = write_pulse ? CMD_WRITE : cmd_q;
  assign res_accept   = res.accept;
  assign res_error    = res.error;
  assign res_cycles   = res.cycles;

  cicero_reg_write_issuer #(.REG_WIDTH(REG_WIDTH)) u_issuer (
    .clk              (clk),
    .rst              (rst),
    .enable           (state == S_LOAD),
    .word_valid       (in_valid),
    .word_addr        (byte_addr >> 2),
    .word             (in_data),
    .word_ready       (issuer_ready),
    .write_pulse      (write_pulse),
    .done             (issuer_done),
    .address_register (address_register),
    .data_in_register (data_in_register)
  );

  // Malformed jobs are drained without ever touching AXI_top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= S_IDLE;
      res                       <= '0;
      res_valid                 <= 1'b0;
      cw                        <= '0;
      sb                        <= '0;
      words_left                <= '0;
      byte_addr                 <= '0;
      cmd_q                     <= CMD_NOP;
      timer                     <= '0;
      start_cc_pointer_register <= '0;
      end_cc_pointer_register   <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_HDR;
        S_HDR: begin
          if (accept) begin
            cw         <= hdr_cw;
            sb         <= hdr_sb;
            words_left <= hdr_words;
            byte_addr  <= '0;
            res        <= '0;
            if (hdr_bad) begin
              res.error <= 1'b1;
              if (hdr_words == 18'd0) begin
                res_valid <= 1'b1;
                state     <= S_RESULT;
              end else begin
                state <= S_DRAIN;
              end
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (accept) begin
            words_left <= words_left - 18'd1;
            if (words_left == 18'd1) begin
              res_valid <= 1'b1;
              state     <= S_RESULT;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            byte_addr  <= byte_addr + REG_WIDTH'(4);
            words_left <= words_left - 18'd1;
          end
          if (issuer_done && (words_left == 18'd0)) state <= S_SET_PTR;
        end
        S_SET_PTR: begin
          start_cc_pointer_register <= ptr_base;
          end_cc_pointer_register   <= ptr_base + REG_WIDTH'(sb) - REG_WIDTH'(1);
          state                     <= S_START;
        end
        S_START: begin
          cmd_q <= CMD_START;
          timer <= '0;
          state <= S_WAIT_RUN;
        end
        S_WAIT_RUN: begin
          if (status_register == STATUS_RUNNING) begin
            cmd_q <= CMD_NOP;
            state <= S_WAIT_DONE;
          end else if (timer == TIMER_W'(START_TIMEOUT - 1)) begin
            cmd_q     <= CMD_NOP;
            res.error <= 1'b1;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (status_register != STATUS_RUNNING) begin
            if (status_register == STATUS_ACCEPTED) res.accept <= 1'b1;
            else if (status_register == STATUS_REJECTED) res.accept <= 1'b0;
            else res.error <= 1'b1;
            cmd_q <= CMD_READ_ELAPSED_CLOCK;
            state <= S_READ_CC;
          end
        end
        S_READ_CC: begin
          cmd_q <= CMD_NOP;
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          res.cycles <= data_o_register;
          res_valid  <= 1'b1;
          state      <= S_RESULT;
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
